gaussian_5x5_filter: RTL and testbench

- Downstream consumer of the 5-row line buffer in the Gaussian path.
- Accepts one 5-pixel column per beat (top row = oldest line) and builds a sliding 5x5 window.
- Applies the separable binomial kernel [1 4 6 4 1] x [1 4 6 4 1] / 256 and emits one rounded 8-bit pixel per interior position, tagged with centre coordinates.
- Handles downstream backpressure and propagates it upstream through a ready signal.

---
 rtl/gaussian_5x5_filter.sv | 215 +++++++++++++++++++++
 tb/tb_gaussian_5x5_filter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_5x5_filter.sv
// gaussian_5x5_filter
//
// Sliding 5x5 binomial blur. It takes one 5-pixel column per beat from the
// 5-row line buffer (col0 = oldest line, col4 = newest line). It emits one
// rounded pixel per interior position, tagged with the window-centre
// coordinates. The kernel is [1 4 6 4 1] x [1 4 6 4 1] / 256, applied
// separably: a vertical sum per column, then a horizontal sum over five
// column sums.
//
// Handshake: a beat transfers on a rising edge where valid_in & in_ready.
// An output pixel transfers on a rising edge where valid_out & out_ready.
// in_ready is combinationally out_ready. The whole pipeline advances only
// when out_ready is high. While out_ready is low every register holds, so a
// presented output stays stable until it is taken.
//
// Optional build macro GAUSS_BYPASS_EN adds a 'bypass' input. When bypass
// is set at the output stage, the unfiltered centre pixel is emitted instead
// of the blurred value. Latency, valid and tags are the same in both modes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in/in_ready column beat handshake
//   col0..col4        column pixels, top (oldest) to bottom (newest)
//   lb_valid          line buffer holds 4 complete lines
//   out_ready         downstream ready
//   valid_out         output pixel valid
//   pix_out           filtered pixel
//   x_out, y_out      centre column / row of pix_out
//   last_out          final pixel of the frame
//   bypass            (GAUSS_BYPASS_EN only) emit the raw centre pixel
module gaussian_5x5_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         col0,
  input  logic [DATA_WIDTH-1:0]         col1,
  input  logic [DATA_WIDTH-1:0]         col2,
  input  logic [DATA_WIDTH-1:0]         col3,
  input  logic [DATA_WIDTH-1:0]         col4,
  input  logic                          lb_valid,
  input  logic                          out_ready,
`ifdef GAUSS_BYPASS_EN
  input  logic                          bypass,
`endif
  output logic                          valid_out,
  output logic [DATA_WIDTH-1:0]         pix_out,
  output logic [$clog2(IMG_WIDTH)-1:0]  x_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] y_out,
  output logic                          last_out
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  // Vertical sum of 16 * max pixel needs 4 extra bits.
  localparam int VW = DATA_WIDTH + 4;
  // Full 2-D sum of 256 * max pixel needs 8 extra bits.
  localparam int HW = DATA_WIDTH + 8;
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);

  // [1 4 6 4 1] weighting with shifts only. No term can overflow the result
  // width because the weights sum to 16.
  function automatic logic [VW-1:0] vsum5(
    input logic [DATA_WIDTH-1:0] a, b, c, d, e);
    logic [VW-1:0] aa, bb, cc, dd, ee;
    aa = VW'(a); bb = VW'(b); cc = VW'(c); dd = VW'(d); ee = VW'(e);
    return aa + (bb << 2) + (cc << 2) + (cc << 1) + (dd << 2) + ee;
  endfunction

  function automatic logic [HW-1:0] hsum5(
    input logic [VW-1:0] a, b, c, d, e);
    logic [HW-1:0] aa, bb, cc, dd, ee;
    aa = HW'(a); bb = HW'(b); cc = HW'(c); dd = HW'(d); ee = HW'(e);
    return aa + (bb << 2) + (cc << 2) + (cc << 1) + (dd << 2) + ee;
  endfunction

  logic acc;
  logic en;

  assign in_ready = out_ready;
  assign en       = out_ready;
  assign acc      = valid_in & out_ready;

  // ---------------------------------------------------------------------
  // Raster position of the incoming column
  // ---------------------------------------------------------------------
  logic [XW-1:0] col_cnt;
  logic [YW-1:0] row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (acc) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + YW'(1);
      end else begin
        col_cnt <= col_cnt + XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: vertical sums into a 5-column window (vwin[0] = oldest)
  // ---------------------------------------------------------------------
  logic [VW-1:0] vwin [5];
  logic          v1;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic          l1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) vwin[i] <= '0;
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      l1 <= 1'b0;
    end else if (en) begin
      // A window is complete only once 4 columns of this row and 4 lines
      // of this frame precede the incoming beat. Earlier beats still fill
      // the window but produce no output, so there is no border padding.
      v1 <= acc & lb_valid & (col_cnt >= XW'(4)) & (row_cnt >= YW'(4));
      if (acc) begin
        for (int i = 0; i < 4; i++) vwin[i] <= vwin[i+1];
        vwin[4] <= vsum5(col0, col1, col2, col3, col4);
        x1      <= col_cnt - XW'(2);
        y1      <= row_cnt - YW'(2);
        l1      <= (col_cnt == COL_LAST) & (row_cnt == ROW_LAST);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: horizontal sum over the window
  // ---------------------------------------------------------------------
  logic [HW-1:0] hsum;
  logic          v2;
  logic [XW-1:0] x2;
  logic [YW-1:0] y2;
  logic          l2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsum <= '0;
      v2   <= 1'b0;
      x2   <= '0;
      y2   <= '0;
      l2   <= 1'b0;
    end else if (en) begin
      hsum <= hsum5(vwin[0], vwin[1], vwin[2], vwin[3], vwin[4]);
      v2   <= v1;
      x2   <= x1;
      y2   <= y1;
      l2   <= l1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: round to nearest and divide by 256. The sum is at most
  // 256 * max pixel, so the rounded quotient always fits DATA_WIDTH.
  // ---------------------------------------------------------------------
  logic [HW-1:0]         rnd;
  logic [DATA_WIDTH-1:0] blur_pix;

  assign rnd      = hsum + HW'(128);
  assign blur_pix = rnd[HW-1:8];

`ifdef GAUSS_BYPASS_EN
  // Raw centre pixels travel alongside the sums. cwin[2] is the centre
  // column of the window that stage 2 is summing.
  logic [DATA_WIDTH-1:0] cwin [5];
  logic [DATA_WIDTH-1:0] c2_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) cwin[i] <= '0;
      c2_pix <= '0;
    end else if (en) begin
      if (acc) begin
        for (int i = 0; i < 4; i++) cwin[i] <= cwin[i+1];
        cwin[4] <= col2;
      end
      c2_pix <= cwin[2];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= '0;
      valid_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      last_out  <= 1'b0;
    end else if (en) begin
`ifdef GAUSS_BYPASS_EN
      pix_out <= bypass ? c2_pix : blur_pix;
`else
      pix_out <= blur_pix;
`endif
      valid_out <= v2;
      x_out     <= x2;
      y_out     <= y2;
      last_out  <= l2;
    end
  end

endmodule

// File: tb/tb_gaussian_5x5_filter.sv
// tb_gaussian_5x5_filter
//
// Directed bench for gaussian_5x5_filter on an 8x8 frame. The frames are:
// flat, impulse, random with bubbles and a stall, random with a mid-frame
// reset, and random after that reset. Expected pixels come from a direct
// 2-D convolution over the bench's own image, held in an expected queue.
// Hand-computed impulse responses are checked separately.
module tb_gaussian_5x5_filter;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int EW = 1 + 3 + 3 + DW;  // {last, y, x, pix}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          valid_in;
  logic          in_ready;
  logic [DW-1:0] col_v [5];
  logic          lb_valid;
  logic          out_ready;
  logic          bypass;
  logic          valid_out;
  logic [DW-1:0] pix_out;
  logic [2:0]    x_out;
  logic [2:0]    y_out;
  logic          last_out;

  gaussian_5x5_filter #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .col0      (col_v[0]),
    .col1      (col_v[1]),
    .col2      (col_v[2]),
    .col3      (col_v[3]),
    .col4      (col_v[4]),
    .lb_valid  (lb_valid),
    .out_ready (out_ready),
`ifdef GAUSS_BYPASS_EN
    .bypass    (bypass),
`endif
    .valid_out (valid_out),
    .pix_out   (pix_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .last_out  (last_out)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] img [IH][IW];
  logic [DW-1:0] obs [IH][IW];
  int            kern [5] = '{1, 4, 6, 4, 1};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int conv_pix(input int x, input int y);
    int s = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        s += kern[i] * kern[j] * int'(img[y-2+i][x-2+j]);
    return (s + 128) >> 8;
  endfunction

  task automatic push_expected(input bit byp);
    logic [DW-1:0] p;
    logic [2:0]    xs, ys;
    for (int y = 2; y < IH - 2; y++)
      for (int x = 2; x < IW - 2; x++) begin
        p  = byp ? img[y][x] : DW'(conv_pix(x, y));
        xs = 3'(x);
        ys = 3'(y);
        exp_q.push_back({(x == IW - 3 && y == IH - 3) ? 1'b1 : 1'b0, ys, xs, p});
      end
  endtask

  // An output transfers at the next rising edge when valid_out & out_ready.
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (rst_n && valid_out && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out", 32'({last_out, y_out, x_out, pix_out}), 32'(e));
      end
      obs[y_out][x_out] = pix_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) obs[y][x] = '0;
  endtask

  task automatic set_column(input int r, input int c, input bit lb_hi);
    lb_valid = (r >= 4) || lb_hi;
    for (int k = 0; k < 5; k++)
      col_v[k] = (r >= 4) ? img[r-4+k][c] : DW'($urandom_range(255));
  endtask

  task automatic stall_5(input string tag);
    logic          sv;
    logic [DW-1:0] sp;
    logic [2:0]    sx;
    sv = valid_out; sp = pix_out; sx = x_out;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_valid"}, 32'(valid_out), 32'(sv));
      check({tag, "_pix"}, 32'(pix_out), 32'(sp));
      check({tag, "_x"}, 32'(x_out), 32'(sx));
    end
    out_ready = 1'b1;
  endtask

  // Sends one frame in raster order. Optional features: random bubbles
  // (gap percent), a 5-cycle stall before beat (sr,sc), an asynchronous
  // reset before beat (rr,rc), and latency probing at beat (4,4).
  task automatic send_frame(input int gap, input bit lb_hi,
                            input int sr, input int sc,
                            input int rr, input int rc,
                            input bit lat, input bit byp);
    push_expected(byp);
    bypass = byp;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        if (r == rr && c == rc) begin
          rst_n = 1'b0;
          #1;
          check("rst_valid", 32'(valid_out), 32'd0);
          check("rst_pix", 32'(pix_out), 32'd0);
          check("rst_xy", 32'({y_out, x_out}), 32'd0);
          exp_q.delete();
          @(posedge clk); #1;
          rst_n = 1'b1;
          valid_in = 1'b0;
          return;
        end
        if ($urandom_range(99) < gap)
          repeat ($urandom_range(3, 1)) begin
            @(posedge clk); #1;
          end
        set_column(r, c, lb_hi);
        valid_in = 1'b1;
        if (r == sr && c == sc) stall_5("stall");
        @(posedge clk); #1;
        valid_in = 1'b0;
        if (lat && r == 4 && c == 4) begin
          check("lat_e0", 32'(valid_out), 32'd0);
          @(posedge clk); #1;
          check("lat_e1", 32'(valid_out), 32'd0);
          @(posedge clk); #1;
          check("lat_e2", 32'(valid_out), 32'd1);
        end
      end
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("drain_q", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random();
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) img[y][x] = DW'($urandom_range(255));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; valid_in = 1'b0; out_ready = 1'b1; lb_valid = 1'b0;
    bypass = 1'b0;
    for (int k = 0; k < 5; k++) col_v[k] = '0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_pix", 32'(pix_out), 32'd0);
    check("reset_x", 32'(x_out), 32'd0);
    check("reset_y", 32'(y_out), 32'd0);
    check("reset_last", 32'(last_out), 32'd0);
    check("ready_hi", 32'(in_ready), 32'd1);
    out_ready = 1'b0; #1;
    check("ready_lo", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Flat frame: every output is exactly 100, with latency probed.
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) img[y][x] = 8'd100;
    send_frame(0, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0);

    // Impulse of 255 at (4,4).
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) img[y][x] = '0;
    img[4][4] = 8'd255;
    clear_obs();
    send_frame(0, 1'b1, -1, -1, -1, -1, 1'b0, 1'b0);
    check("imp_4_4", 32'(obs[4][4]), 32'd36);
    check("imp_3_4", 32'(obs[4][3]), 32'd24);
    check("imp_2_2", 32'(obs[2][2]), 32'd1);

    // Random image with bubbles, lb_valid held high, stall on a valid pixel.
    fill_random();
    send_frame(30, 1'b1, 5, 6, -1, -1, 1'b0, 1'b0);

    // Mid-frame reset while outputs are flowing.
    fill_random();
    send_frame(0, 1'b1, -1, -1, 6, 5, 1'b0, 1'b0);

    // The next frame after the reset starts cleanly at (2,2).
    fill_random();
    send_frame(20, 1'b0, 6, 4, -1, -1, 1'b0, 1'b0);

`ifdef GAUSS_BYPASS_EN
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) img[y][x] = '0;
    img[4][4] = 8'd255;
    clear_obs();
    send_frame(0, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1);
    check("byp_4_4", 32'(obs[4][4]), 32'd255);
    check("byp_2_2", 32'(obs[2][2]), 32'd0);
    bypass = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
